// File: rtl/mac_pe_os.sv
// Output-stationary MAC processing element: forwards operands east/south and
// accumulates framed dot products. Define MAC_SAT_EN for saturating accumulation.
module mac_pe_os #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter bit          SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic              last_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vld_in,
    input  logic              acc_clr,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic              last_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_vld_out,
    output logic [ACC_W-1:0]  res,
    output logic              res_vld,
    input  logic              res_rdy,
    output logic              ovf_err,
    output logic              sat_flag
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned EXT_W  = ACC_W - PROD_W;

    typedef enum logic {IDLE, ACC} state_t;

    state_t              state;
    logic [ACC_W-1:0]    acc;
    logic [PROD_W-1:0]   a_x;
    logic [PROD_W-1:0]   b_x;
    logic [PROD_W-1:0]   prod_n;
    logic [ACC_W-1:0]    prod;
    logic [ACC_W-1:0]    base;
    logic [ACC_W-1:0]    sum;
    logic                fire;
    logic                new_res;

    assign fire    = a_vld_in & b_vld_in;
    assign new_res = fire & last_in & ~acc_clr;

    // Operands extended to the full product width so the low product bits are exact
    assign a_x    = {{DATA_W{SIGNED & a_in[DATA_W-1]}}, a_in};
    assign b_x    = {{DATA_W{SIGNED & b_in[DATA_W-1]}}, b_in};
    assign prod_n = a_x * b_x;

    generate
        if (EXT_W == 0) begin : g_prod_full
            assign prod = prod_n;
        end else begin : g_prod_ext
            assign prod = {{EXT_W{SIGNED & prod_n[PROD_W-1]}}, prod_n};
        end
    endgenerate

    assign base = (state == ACC) ? acc : '0;

`ifdef MAC_SAT_EN
    logic [ACC_W:0] sum_w;
    logic           clamp;

    // One guard bit detects overflow; clamp to the representable range
    always_comb begin
        sum_w = {SIGNED & base[ACC_W-1], base} + {SIGNED & prod[ACC_W-1], prod};
        clamp = SIGNED ? (sum_w[ACC_W] ^ sum_w[ACC_W-1]) : sum_w[ACC_W];
        sum   = sum_w[ACC_W-1:0];
        if (clamp) begin
            if (!SIGNED)
                sum = '1;
            else if (sum_w[ACC_W])
                sum = {1'b1, {(ACC_W-1){1'b0}}};
            else
                sum = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_flag <= 1'b0;
        else if (fire && !acc_clr && clamp)
            sat_flag <= 1'b1;
    end
`else
    assign sum      = base + prod;
    assign sat_flag = 1'b0;
`endif

    // Forwarding, accumulator state machine and result port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            a_out     <= '0;
            a_vld_out <= 1'b0;
            last_out  <= 1'b0;
            b_out     <= '0;
            b_vld_out <= 1'b0;
            res       <= '0;
            res_vld   <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            a_out     <= a_in;
            a_vld_out <= a_vld_in;
            last_out  <= last_in;
            b_out     <= b_in;
            b_vld_out <= b_vld_in;

            if (acc_clr) begin
                state <= IDLE;
                acc   <= '0;
            end else if (fire) begin
                if (last_in) begin
                    state <= IDLE;
                    acc   <= '0;
                end else begin
                    state <= ACC;
                    acc   <= sum;
                end
            end

            // A new result wins over a same-cycle transfer; overwrite only when unconsumed
            if (new_res) begin
                res     <= sum;
                res_vld <= 1'b1;
                if (res_vld && !res_rdy)
                    ovf_err <= 1'b1;
            end else if (res_vld && res_rdy) begin
                res_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_pe_os.sv
// Self-checking bench for mac_pe_os: directed test-plan scenarios, then random
// traffic against an integer-arithmetic dot-product model (honours MAC_SAT_EN).
module tb_mac_pe_os;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 16;
    localparam longint      MAXV   = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint      MINV   = -(64'sd1 <<< (ACC_W - 1));

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] a_in = '0;
    logic              a_vld_in = 1'b0;
    logic              last_in = 1'b0;
    logic [DATA_W-1:0] b_in = '0;
    logic              b_vld_in = 1'b0;
    logic              acc_clr = 1'b0;
    logic [DATA_W-1:0] a_out;
    logic              a_vld_out;
    logic              last_out;
    logic [DATA_W-1:0] b_out;
    logic              b_vld_out;
    logic [ACC_W-1:0]  res;
    logic              res_vld;
    logic              res_rdy = 1'b0;
    logic              ovf_err;
    logic              sat_flag;

    mac_pe_os #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_vld_in(a_vld_in), .last_in(last_in),
        .b_in(b_in), .b_vld_in(b_vld_in), .acc_clr(acc_clr),
        .a_out(a_out), .a_vld_out(a_vld_out), .last_out(last_out),
        .b_out(b_out), .b_vld_out(b_vld_out),
        .res(res), .res_vld(res_vld), .res_rdy(res_rdy),
        .ovf_err(ovf_err), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference state: partial dot product as a plain integer
    longint            m_part;
    bit                m_busy;
    longint            m_res;
    bit                m_vld, m_ovf, m_sat;
    logic [DATA_W-1:0] e_a, e_b;
    bit                e_av, e_bv, e_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] acc64(input longint v);
        logic [ACC_W-1:0] t;
        t = ACC_W'(v);
        return 64'(t);
    endfunction

    task automatic model_reset();
        m_part = 0; m_busy = 0; m_res = 0; m_vld = 0; m_ovf = 0; m_sat = 0;
        e_a = '0; e_b = '0; e_av = 0; e_bv = 0; e_last = 0;
    endtask

    function automatic longint fit(input longint v, inout bit sat);
        logic [ACC_W-1:0] t;
`ifdef MAC_SAT_EN
        t = '0;
        if (v > MAXV) begin sat = 1; return MAXV; end
        if (v < MINV) begin sat = 1; return MINV; end
        return v;
`else
        t = ACC_W'(v);
        return longint'($signed(t));
`endif
    endfunction

    task automatic model_step(input logic [DATA_W-1:0] a, input bit av,
                              input logic [DATA_W-1:0] b, input bit bv,
                              input bit lst, input bit clr, input bit rdy);
        longint s;
        bit     produced;
        produced = 0;
        s = 0;
        e_a = a; e_b = b; e_av = av; e_bv = bv; e_last = lst;
        if (clr) begin
            m_busy = 0; m_part = 0;
        end else if (av && bv) begin
            s = (m_busy ? m_part : 0) + longint'($signed(a)) * longint'($signed(b));
            s = fit(s, m_sat);
            if (lst) begin
                produced = 1; m_busy = 0; m_part = 0;
            end else begin
                m_busy = 1; m_part = s;
            end
        end
        if (produced) begin
            if (m_vld && !rdy) m_ovf = 1;
            m_res = s;
            m_vld = 1;
        end else if (m_vld && rdy) begin
            m_vld = 0;
        end
    endtask

    task automatic compare_all();
        check("a_out",     64'(a_out),     64'(e_a));
        check("a_vld_out", 64'(a_vld_out), 64'(e_av));
        check("last_out",  64'(last_out),  64'(e_last));
        check("b_out",     64'(b_out),     64'(e_b));
        check("b_vld_out", 64'(b_vld_out), 64'(e_bv));
        check("res_vld",   64'(res_vld),   64'(m_vld));
        check("res",       64'(res),       acc64(m_res));
        check("ovf_err",   64'(ovf_err),   64'(m_ovf));
        check("sat_flag",  64'(sat_flag),  64'(m_sat));
    endtask

    // Apply inputs, clock once, advance the model and compare everything
    task automatic step(input int a, input bit av, input int b, input bit bv,
                        input bit lst, input bit clr, input bit rdy);
        a_in = DATA_W'(a); a_vld_in = av; b_in = DATA_W'(b); b_vld_in = bv;
        last_in = lst; acc_clr = clr; res_rdy = rdy;
        @(posedge clk);
        #1;
        cyc++;
        model_step(DATA_W'(a), av, DATA_W'(b), bv, lst, clr, rdy);
        compare_all();
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Dot product (3,4)+(-2,5)+(7,-1) = -5, one-cycle res_vld pulse
        step(3, 1, 4, 1, 0, 0, 1);
        step(-2, 1, 5, 1, 0, 0, 1);
        step(7, 1, -1, 1, 1, 0, 1);
        check("dot_res", 64'(res), acc64(-5));
        check("dot_vld", 64'(res_vld), 64'(1));
        check("dot_a_echo", 64'(a_out), 64'(8'd7));
        idle(1);
        check("dot_vld_drop", 64'(res_vld), 64'(0));

        // Valid gaps: only a valid for two cycles
        step(2, 1, 2, 1, 0, 0, 1);
        step(9, 1, 9, 0, 0, 0, 1);
        step(8, 1, 8, 0, 0, 0, 1);
        step(3, 1, 3, 1, 1, 0, 1);
        check("gap_res", 64'(res), acc64(13));
        idle(1);

        // Backpressure: second single-term result overwrites the first
        step(5, 1, 5, 1, 1, 0, 0);
        step(6, 1, 6, 1, 1, 0, 0);
        check("bp_res", 64'(res), acc64(36));
        check("bp_vld", 64'(res_vld), 64'(1));
        check("bp_ovf", 64'(ovf_err), 64'(1));
        idle(1);
        check("bp_vld_drop", 64'(res_vld), 64'(0));

        // acc_clr discards the simultaneous fire
        step(10, 1, 10, 1, 0, 0, 1);
        step(1, 1, 1, 1, 0, 1, 1);
        step(2, 1, 3, 1, 1, 0, 1);
        check("abort_res", 64'(res), acc64(6));
        idle(1);

        // Asynchronous reset between edges mid-accumulation
        step(9, 1, 9, 1, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_res", 64'(res), 64'(0));
        check("arst_a_out", 64'(a_out), 64'(0));
        check("arst_ovf", 64'(ovf_err), 64'(0));
        compare_all();
        #2 rst = 1'b0;
        step(4, 1, 4, 1, 1, 0, 1);
        check("post_rst_res", 64'(res), acc64(16));
        idle(1);

        // Saturation / wrap with 3 x (127,127)
        step(127, 1, 127, 1, 0, 0, 1);
        step(127, 1, 127, 1, 0, 0, 1);
        step(127, 1, 127, 1, 1, 0, 1);
`ifdef MAC_SAT_EN
        check("sat_res", 64'(res), acc64(32767));
        check("sat_flag_set", 64'(sat_flag), 64'(1));
`else
        check("wrap_res", 64'(res), 64'(16'hBD03));
        check("sat_flag_zero", 64'(sat_flag), 64'(0));
`endif
        idle(1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_pe_os.md
Name: mac_pe_os

Overview:
- Parametrised output-stationary processing element; next generation of the basic 8-bit systolic MAC cell.
- Forwards operands east/south with valid and last tags; accumulates only when both operands are valid.
- Frames a dot product with a `last` tag and presents the finished sum through a ready/valid result port.
- Tiled N x M in the systolic array top level; the result ports feed a drain/collect stage.

Parameters:
- DATA_W, 8, operand width (two's complement, or unsigned if SIGNED=0).
- ACC_W, 32, accumulator/result width; must be >= 2*DATA_W.
- SIGNED, 1, 1 = signed multiply with sign extension to ACC_W; 0 = unsigned with zero extension.

Ports:
- clk  in  1  clock; all registers on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_in  in  DATA_W  west operand.
- a_vld_in  in  1  a_in valid.
- last_in  in  1  marks the final a/b pair of the current dot product; qualified by a fire.
- b_in  in  DATA_W  north operand.
- b_vld_in  in  1  b_in valid.
- acc_clr  in  1  synchronous abort of the partial sum.
- a_out  out  DATA_W  registered a_in to the east neighbour.
- a_vld_out  out  1  registered a_vld_in.
- last_out  out  1  registered last_in.
- b_out  out  DATA_W  registered b_in to the south neighbour.
- b_vld_out  out  1  registered b_vld_in.
- res  out  ACC_W  completed dot product.
- res_vld  out  1  res holds an unconsumed result.
- res_rdy  in  1  consumer accepts res.
- ovf_err  out  1  sticky: a result was overwritten before it was accepted.
- sat_flag  out  1  sticky saturation indicator (see Optional Feature).

Behaviour:
- Reset: every output register and the accumulator are 0, and the state is IDLE.
- Forwarding:
  - a_out, a_vld_out, last_out, b_out and b_vld_out are registered copies of their inputs; latency 1 cycle.
  - Forwarding is unconditional, regardless of fire, acc_clr or result state.
- Fire: fire = a_vld_in & b_vld_in. If only one operand is valid, no MAC occurs and the accumulator holds.
- Arithmetic:
  - prod = a_in*b_in at 2*DATA_W bits, extended to ACC_W (sign- or zero-extension per SIGNED).
  - sum = base + prod, where base = 0 in IDLE and acc in ACC.
  - The sum wraps modulo 2^ACC_W unless MAC_SAT_EN is defined.
- State machine: IDLE (no partial sum) and ACC (partial sum in progress).
  - IDLE, fire & !last_in -> ACC; acc <= prod.
  - IDLE, fire & last_in -> IDLE; single-term result, res <= prod.
  - ACC, fire & !last_in -> ACC; acc <= sum.
  - ACC, fire & last_in -> IDLE; res <= sum, acc <= 0.
  - Any state, acc_clr -> IDLE; acc <= 0. acc_clr has priority over a simultaneous fire: that product is discarded and no result is produced. res, res_vld and ovf_err are unaffected.
- Result handshake:
  - res_vld rises the cycle after the last fire; res is stable while res_vld=1.
  - Transfer occurs on res_vld & res_rdy; res_vld then clears next cycle unless a new result loads in the same cycle.
  - Simultaneous transfer and new result: the new result loads and res_vld stays 1; ovf_err does not set.
  - New result while res_vld=1 and !res_rdy: res is overwritten and ovf_err sets. ovf_err clears only on rst.
- Latency: the result appears 1 cycle after the fire carrying last_in.
- Reset mid-operation: the partial sum, any pending result and all forwarded data are lost immediately (asynchronous).

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: sum is clamped to the ACC_W range (signed range for SIGNED=1, [0, 2^ACC_W-1] for SIGNED=0), and sat_flag sets sticky on any clamp. sat_flag clears only on rst.
- Undefined: modular wrap; sat_flag tied to 0.

Test Plan:
- Dot product: defaults, (a,b) pairs (3,4), (-2,5), (7,-1) back-to-back with last on the 3rd, res_rdy=1 -> res=-5 with a 1-cycle res_vld pulse one cycle after the 3rd fire; a_out/b_out echo the inputs 1 cycle later.
- Valid gaps: a_vld only for 2 cycles between two fires (2,2),(3,3)+last -> no accumulation during the gaps; res=13.
- Backpressure: res_rdy=0, two single-term results 5*5 then 6*6 -> res=36, res_vld=1, ovf_err=1; assert res_rdy -> res_vld clears next cycle.
- Abort priority: after (10,10), apply acc_clr together with (1,1) fire, then (2,3)+last -> res=6, state returns to IDLE.
- Async reset: assert rst mid-accumulation, between clock edges -> all outputs 0 immediately; next frame (4,4)+last -> res=16.
- Saturation: ACC_W=16, MAC_SAT_EN defined, 3 x (127,127) with last on the 3rd -> res=32767, sat_flag=1. Without the macro -> res=48387 mod 2^16 = -17149 (0xBD03), sat_flag=0.
